system_ram_reader: RTL and testbench

SYSTEM_RAM_READER -- requirements
Module: system_ram_reader

---
 rtl/system_ram_reader.sv | 176 +++++++++++++++++
 tb/tb_system_ram_reader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/system_ram_reader.sv
// system_ram_reader
//   Streams `length` consecutive words out of a single-port synchronous RAM,
//   starting at `base_addr` and wrapping from RAM_WORDS-1 back to 0. Read
//   data lands in a small show-ahead FIFO. The FIFO feeds a valid/ready
//   stream that can stall at any time.
//
// Ports
//   clk, reset         : rising-edge clock, synchronous active-high reset
//   start              : one-cycle request, honoured only when idle
//   base_addr, length  : transfer descriptor, captured with start
//   busy, done         : busy while reading/draining; one-cycle done pulse
//   ram_*              : RAM read port (one-cycle read latency)
//   out_data/valid/    : output stream; out_last marks the final word
//   ready/last
module system_ram_reader #(
  parameter int unsigned RAM_WORDS  = 1280,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] base_addr,
  input  logic [10:0] length,
  output logic        busy,
  output logic        done,
  output logic [10:0] ram_address,
  output logic        ram_chipselect,
  output logic        ram_write,
  output logic [3:0]  ram_byteenable,
  output logic        ram_clken,
  input  logic [31:0] ram_readdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam logic [10:0] LastAddr = 11'(RAM_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [10:0]     addr_q, addr_d;
  logic [10:0]     len_q, len_d;
  logic [10:0]     issued_q, issued_d;
  logic [10:0]     popped_q, popped_d;
  logic            inflight_q, inflight_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] fifo_count_q, fifo_count_d;
  logic [31:0]     mem_q [FIFO_DEPTH];

  logic issue;
  logic push;
  logic pop;
  logic fifo_empty;
  logic has_space;

  assign fifo_empty = (fifo_count_q == '0);
  // Reserve a slot for the read already in flight so the FIFO can never overflow.
  assign has_space  = (fifo_count_q + CntW'(inflight_q)) < CntW'(FIFO_DEPTH);
  assign push       = inflight_q;
  assign pop        = !fifo_empty && out_ready;

  // Transfer control
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    popped_d   = popped_q;
    issue      = 1'b0;

    if (pop) begin
      popped_d = popped_q + 11'd1;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          addr_d   = base_addr;
          len_d    = length;
          issued_d = '0;
          popped_d = '0;
          state_d  = (length == 11'd0) ? StDone : StRead;
        end
      end
      StRead: begin
        if (has_space) begin
          issue    = 1'b1;
          issued_d = issued_q + 11'd1;
          addr_d   = (addr_q == LastAddr) ? 11'd0 : addr_q + 11'd1;
          if (issued_q == len_q - 11'd1) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (fifo_empty && !inflight_q && (popped_q == len_q)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FIFO pointer / occupancy update
  always_comb begin
    inflight_d   = issue;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      fifo_count_d = fifo_count_q + CntW'(1);
    end else if (!push && pop) begin
      fifo_count_d = fifo_count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      len_q        <= '0;
      issued_q     <= '0;
      popped_q     <= '0;
      inflight_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      issued_q     <= issued_d;
      popped_q     <= popped_d;
      inflight_q   <= inflight_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  // Storage needs no reset: the pointers and count decide what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ram_readdata;
    end
  end

  assign busy           = (state_q == StRead) || (state_q == StDrain);
  assign done           = (state_q == StDone);
  assign ram_address    = addr_q;
  assign ram_chipselect = issue;
  assign ram_write      = 1'b0;
  assign ram_byteenable = 4'hF;
  assign ram_clken      = 1'b1;
  assign out_valid      = !fifo_empty;
  // Zero the head when empty so stale storage never shows on the stream.
  assign out_data       = fifo_empty ? 32'd0 : mem_q[rd_ptr_q];
  assign out_last       = out_valid && (popped_q == len_q - 11'd1);

endmodule

// File: tb/tb_system_ram_reader.sv
module tb_system_ram_reader;
  localparam int unsigned RamWords = 1280;
  localparam int unsigned Depth    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] base_addr;
  logic [10:0] length;
  logic        busy;
  logic        done;
  logic [10:0] ram_address;
  logic        ram_chipselect;
  logic        ram_write;
  logic [3:0]  ram_byteenable;
  logic        ram_clken;
  logic [31:0] ram_readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  int total = 0;
  int bad   = 0;

  system_ram_reader #(
    .RAM_WORDS (RamWords),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .ram_address   (ram_address),
    .ram_chipselect(ram_chipselect),
    .ram_write     (ram_write),
    .ram_byteenable(ram_byteenable),
    .ram_clken     (ram_clken),
    .ram_readdata  (ram_readdata),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last)
  );

  always #5 clk = ~clk;

  // RAM model: data[i] = i, one-cycle read latency
  logic [31:0] ram [RamWords];
  initial begin
    for (int i = 0; i < RamWords; i++) ram[i] = i;
    ram_readdata = 32'd0;
  end
  always @(posedge clk) begin
    if (ram_chipselect && !ram_write && (ram_address < 11'(RamWords)))
      ram_readdata <= ram[ram_address];
  end

  // Results of the most recent collect() run
  logic [31:0] got_data[$];
  bit          got_last[$];
  int          got_cyc[$];
  int          cs_addr[$];
  int          cs_cyc[$];
  int          done_cnt, done_cyc, valid_seen, max_cnt, overfill, stall_cyc, busy_after;
  bit          busy_c1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int b, input int l);
    base_addr = 11'(b);
    length    = 11'(l);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Runs the cycles after a start; records stream, read requests and done.
  task automatic collect(input int ready_pct, input int want_len, input int restart_at,
                         input int max_cyc);
    int post;
    int fc;
    post = -1;
    got_data.delete(); got_last.delete(); got_cyc.delete();
    cs_addr.delete(); cs_cyc.delete();
    done_cnt = 0; done_cyc = -1; valid_seen = 0; max_cnt = 0;
    overfill = 0; stall_cyc = 0; busy_after = 0; busy_c1 = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      out_ready = ($urandom_range(0, 99) < ready_pct);
      if (c == restart_at) begin
        start = 1'b1; base_addr = 11'd100; length = 11'd3;
      end
      @(negedge clk);
      fc = int'(dut.fifo_count_q);
      if (c == 1) busy_c1 = busy;
      if (fc > max_cnt) max_cnt = fc;
      if (ram_chipselect && (fc + int'(dut.inflight_q) >= Depth)) overfill++;
      if (busy && !ram_chipselect && cs_addr.size() < want_len) stall_cyc++;
      if (ram_chipselect) begin
        cs_addr.push_back(int'(ram_address));
        cs_cyc.push_back(c);
      end
      if (out_valid) valid_seen++;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        got_cyc.push_back(c);
      end
      if (post > 0 && busy) busy_after++;
      if (done) begin
        done_cnt++;
        if (post < 0) begin
          post = 0;
          done_cyc = c;
        end
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (post >= 0) post++;
      if (post > 2) break;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", out_last); end
    total++; if (ram_chipselect !== 1'b0) begin bad++; $display("FAIL reset_cs: got %b want 0", ram_chipselect); end
    total++; if (ram_address !== 11'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", ram_address); end
    total++; if (out_data !== 32'd0) begin bad++; $display("FAIL reset_data: got %0h want 0", out_data); end
    total++; if (ram_write !== 1'b0) begin bad++; $display("FAIL ram_write: got %b want 0", ram_write); end
    total++; if (ram_byteenable !== 4'hF) begin bad++; $display("FAIL ram_be: got %h want f", ram_byteenable); end
    total++; if (ram_clken !== 1'b1) begin bad++; $display("FAIL ram_clken: got %b want 1", ram_clken); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] d;
    do_start(0, 8);
    collect(100, 8, 0, 200);
    total++; if (busy_c1 !== 1'b1) begin bad++; $display("FAIL basic_busy_c1: got %b want 1", busy_c1); end
    total++; if (got_data.size() != 8) begin bad++; $display("FAIL basic_count: got %0d want 8", got_data.size()); end
    total++; if (cs_cyc.size() == 0 || cs_cyc[0] != 1) begin bad++; $display("FAIL basic_first_read_cycle: got %0d want 1", cs_cyc.size() == 0 ? -1 : cs_cyc[0]); end
    for (int i = 0; i < 8; i++) begin
      d = (i < got_data.size()) ? got_data[i] : 32'hDEAD_BEEF;
      total++; if (d !== 32'(i)) begin bad++; $display("FAIL basic_data[%0d]: got %0d want %0d", i, d, i); end
      total++; if (i < got_cyc.size() && got_cyc[i] != 3 + i) begin bad++; $display("FAIL basic_cycle[%0d]: got %0d want %0d", i, got_cyc[i], 3 + i); end
      total++; if (i < got_last.size() && got_last[i] != (i == 7)) begin bad++; $display("FAIL basic_last[%0d]: got %0d want %0d", i, got_last[i], i == 7); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
    total++; if (busy_after != 0) begin bad++; $display("FAIL basic_busy_after_done: got %0d want 0", busy_after); end
  endtask

  task automatic test_wrap();
    int          exp_a [6];
    logic [31:0] d;
    int          a;
    exp_a = '{1276, 1277, 1278, 1279, 0, 1};
    do_start(1276, 6);
    collect(100, 6, 0, 200);
    total++; if (cs_addr.size() != 6) begin bad++; $display("FAIL wrap_reads: got %0d want 6", cs_addr.size()); end
    total++; if (got_data.size() != 6) begin bad++; $display("FAIL wrap_count: got %0d want 6", got_data.size()); end
    for (int i = 0; i < 6; i++) begin
      a = (i < cs_addr.size()) ? cs_addr[i] : -1;
      d = (i < got_data.size()) ? got_data[i] : 32'hDEAD_BEEF;
      total++; if (a != exp_a[i]) begin bad++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, a, exp_a[i]); end
      total++; if (d !== 32'(exp_a[i])) begin bad++; $display("FAIL wrap_data[%0d]: got %0d want %0d", i, d, exp_a[i]); end
      total++; if (i < got_last.size() && got_last[i] != (i == 5)) begin bad++; $display("FAIL wrap_last[%0d]: got %0d want %0d", i, got_last[i], i == 5); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL wrap_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_zero_length();
    do_start(5, 0);
    collect(100, 0, 0, 20);
    total++; if (done_cyc != 1) begin bad++; $display("FAIL zero_done_cycle: got %0d want 1", done_cyc); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL zero_done_pulses: got %0d want 1", done_cnt); end
    total++; if (cs_addr.size() != 0) begin bad++; $display("FAIL zero_reads: got %0d want 0", cs_addr.size()); end
    total++; if (valid_seen != 0) begin bad++; $display("FAIL zero_valid: got %0d want 0", valid_seen); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    do_start(40, 20);
    collect(30, 20, 0, 2000);
    total++; if (got_data.size() != 20) begin bad++; $display("FAIL bp_count: got %0d want 20", got_data.size()); end
    for (int i = 0; i < 20; i++) begin
      d = (i < got_data.size()) ? got_data[i] : 32'hDEAD_BEEF;
      total++; if (d !== 32'(40 + i)) begin bad++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, d, 40 + i); end
      total++; if (i < got_last.size() && got_last[i] != (i == 19)) begin bad++; $display("FAIL bp_last[%0d]: got %0d want %0d", i, got_last[i], i == 19); end
    end
    total++; if (max_cnt > Depth) begin bad++; $display("FAIL bp_fifo_max: got %0d want <=%0d", max_cnt, Depth); end
    total++; if (overfill != 0) begin bad++; $display("FAIL bp_read_while_full: got %0d want 0", overfill); end
    total++; if (stall_cyc == 0) begin bad++; $display("FAIL bp_stall_cycles: got %0d want >0", stall_cyc); end
    total++; if (cs_addr.size() != 20) begin bad++; $display("FAIL bp_reads: got %0d want 20", cs_addr.size()); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_midway();
    int          n;
    int          dn;
    int          vn;
    logic [31:0] d;
    do_start(0, 20);
    out_ready = 1'b1;
    n = 0;
    for (int c = 1; c <= 20 && n < 3; c++) begin
      @(negedge clk);
      if (ram_chipselect) n++;
      @(posedge clk); #1;
    end
    total++; if (n != 3) begin bad++; $display("FAIL mid_third_read: got %0d reads want 3", n); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    total++; if (ram_chipselect !== 1'b0) begin bad++; $display("FAIL mid_cs: got %b want 0", ram_chipselect); end
    total++; if (ram_address !== 11'd0) begin bad++; $display("FAIL mid_addr: got %0d want 0", ram_address); end
    total++; if (out_data !== 32'd0) begin bad++; $display("FAIL mid_data: got %0h want 0", out_data); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL mid_last: got %b want 0", out_last); end
    dn = 0; vn = 0;
    for (int c = 0; c < 5; c++) begin
      if (done) dn++;
      if (out_valid) vn++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    total++; if (dn != 0) begin bad++; $display("FAIL mid_no_done: got %0d pulses want 0", dn); end
    total++; if (vn != 0) begin bad++; $display("FAIL mid_discard: got %0d valid cycles want 0", vn); end
    @(posedge clk); #1;
    do_start(0, 2);
    collect(100, 2, 0, 100);
    total++; if (got_data.size() != 2) begin bad++; $display("FAIL mid_after_count: got %0d want 2", got_data.size()); end
    for (int i = 0; i < 2; i++) begin
      d = (i < got_data.size()) ? got_data[i] : 32'hDEAD_BEEF;
      total++; if (d !== 32'(i)) begin bad++; $display("FAIL mid_after_data[%0d]: got %0d want %0d", i, d, i); end
    end
    total++; if (got_last.size() == 2 && got_last[1] != 1'b1) begin bad++; $display("FAIL mid_after_last: got %0d want 1", got_last[1]); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL mid_after_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_restart_ignored();
    logic [31:0] d;
    int          a;
    do_start(10, 6);
    collect(100, 6, 2, 200);
    total++; if (got_data.size() != 6) begin bad++; $display("FAIL restart_count: got %0d want 6", got_data.size()); end
    total++; if (cs_addr.size() != 6) begin bad++; $display("FAIL restart_reads: got %0d want 6", cs_addr.size()); end
    for (int i = 0; i < 6; i++) begin
      d = (i < got_data.size()) ? got_data[i] : 32'hDEAD_BEEF;
      a = (i < cs_addr.size()) ? cs_addr[i] : -1;
      total++; if (d !== 32'(10 + i)) begin bad++; $display("FAIL restart_data[%0d]: got %0d want %0d", i, d, 10 + i); end
      total++; if (a != 10 + i) begin bad++; $display("FAIL restart_addr[%0d]: got %0d want %0d", i, a, 10 + i); end
      total++; if (i < got_last.size() && got_last[i] != (i == 5)) begin bad++; $display("FAIL restart_last[%0d]: got %0d want %0d", i, got_last[i], i == 5); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL restart_done: got %0d want 1", done_cnt); end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = 11'd0;
    length    = 11'd0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_zero_length();
    test_backpressure();
    test_reset_midway();
    test_restart_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
